decoder_3: RTL and testbench
============================

DECODER_3 -- requirements
Module: decoder_3

Interface
REQ-001 Parameter ACTIVE_LOW, default 0: output polarity; 0 gives active-high one-hot y, 1 gives bitwise-inverted y (one-cold).
REQ-002 Parameter REG_OUT, default 1: 1 gives registered outputs; 0 gives combinational y/valid with clk/rst used only by the error flag.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port y, output, 8 bits: decoded one-hot output.
REQ-007 Port a, input, 3 bits: binary select.
REQ-008 Port en, input, 1 bit: decode enable, active-high.
REQ-009 Port valid, output, 1 bit: high when y carries a decoded (enabled) value.
REQ-010 Positional port order SHALL be clk, rst, y, a, en, valid, then the optional ports of REQ-025.

Function
REQ-011 With en=1, the active bit SHALL be y[a] and all other seven bits SHALL be inactive (a=000 gives 00000001; a=111 gives 10000000, for ACTIVE_LOW=0).
REQ-012 With en=0, all eight y bits SHALL be inactive and valid SHALL be 0, regardless of a, including X/Z on a.
REQ-013 With REG_OUT=1, y and valid SHALL update on the rising clk edge that samples en/a, giving exactly 1-cycle latency; outputs SHALL hold between edges.
REQ-014 With REG_OUT=0, y and valid SHALL follow en/a combinationally with zero latency.
REQ-015 valid SHALL equal the sampled en (REG_OUT=1) or the current en (REG_OUT=0).
REQ-016 At most one y bit SHALL be active at any time; no glitch-free guarantee SHALL apply to the combinational mode.
REQ-017 Inactive level SHALL be 0 for ACTIVE_LOW=0 and 1 for ACTIVE_LOW=1; the same rule SHALL apply to the reset value.
REQ-018 When a changes on consecutive enabled cycles, each cycle SHALL produce the decode of that cycle's a, with no skipped or held values.

Reset
REQ-019 Asserting rst SHALL immediately (without clk) force y to all-inactive (8'h00, or 8'hFF when ACTIVE_LOW=1), force valid to 0, and force err to 0 if present.
REQ-020 While rst is high, inputs SHALL be ignored.
REQ-021 The first decode after rst deasserts SHALL appear on the first rising edge sampling en=1 (REG_OUT=1).
REQ-022 Reset asserted mid-sweep SHALL discard the pending decode; no stale value SHALL reappear after release.

Configuration
REQ-023 Macro DECODER_3_PARITY_EN SHALL compile in input-parity checking.
REQ-024 Without DECODER_3_PARITY_EN, the module SHALL have only the ports of REQ-004 to REQ-009 and no parity logic.
REQ-025 With DECODER_3_PARITY_EN defined, the module SHALL add input a_par (1 bit, even parity over a) and output err (1 bit).
REQ-026 With DECODER_3_PARITY_EN, when en=1 and ^a != a_par, y SHALL be all-inactive and valid SHALL be 0 for that decode.
REQ-027 With DECODER_3_PARITY_EN, err SHALL be registered and set on the same edge as the corresponding decode.
REQ-028 With DECODER_3_PARITY_EN, err SHALL stay set (sticky) until rst.

Verification
REQ-029 Reset: assert rst with clk stopped -> y=8'h00, valid=0 immediately.
REQ-030 Disabled: en=0, a=3'bxxx for 3 cycles -> y=8'h00, valid=0, no X on y.
REQ-031 Sweep: en=1, a=000..111 on successive cycles -> y=01,02,04,08,10,20,40,80 each one cycle after its a, valid=1.
REQ-032 Polarity: ACTIVE_LOW=1, en=1, a=011 -> y=8'hF7; with en=0 -> y=8'hFF.
REQ-033 Reset mid-operation: a=101, en=1, assert rst between edges -> y=8'h00 at once; after release with en=0 -> y stays 00.
REQ-034 Parity (macro on): en=1, a=110, a_par=1 -> y=00, valid=0, err=1 sticky until rst; a_par=0 -> y=8'h40.

Source files
------------

// File: rtl/decoder_3.sv
// 3-to-8 one-hot decoder with optional output register and selectable polarity.
// Optional input-parity checking is compiled in with the DECODER_3_PARITY_EN macro.
module decoder_3 #(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit REG_OUT    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] y,
    input  logic [2:0] a,
    input  logic       en,
    output logic       valid
`ifdef DECODER_3_PARITY_EN
    ,
    input  logic       a_par,
    output logic       err
`endif
);

    localparam logic [7:0] IDLE_Y = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic       par_bad;
    logic       decode_en;
    logic [7:0] hot;
    logic [7:0] y_next;

`ifdef DECODER_3_PARITY_EN
    logic err_reg;

    // Only an enabled decode can raise a parity error; a disabled cycle with X on a stays quiet.
    assign par_bad = en & ((^a) ^ a_par);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (par_bad) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign par_bad = 1'b0;
`endif

    // Gating on rst keeps the combinational mode inactive during reset as well.
    assign decode_en = en & ~par_bad & ~rst;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign hot[gi] = decode_en & (a == 3'(gi));
        end
    endgenerate

    assign y_next = ACTIVE_LOW ? ~hot : hot;

    generate
        if (REG_OUT) begin : g_reg
            logic [7:0] y_reg;
            logic       valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_reg     <= IDLE_Y;
                    valid_reg <= 1'b0;
                end else begin
                    y_reg     <= y_next;
                    valid_reg <= decode_en;
                end
            end

            assign y     = y_reg;
            assign valid = valid_reg;
        end else begin : g_comb
            assign y     = y_next;
            assign valid = decode_en;
        end
    endgenerate

endmodule

// File: tb/tb_decoder_3.sv
// Scoreboard bench for decoder_3: registered active-high, registered active-low
// and combinational instances driven from one directed sequence.
module tb_decoder_3;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] a = 3'b000;
    logic       en = 1'b0;
    logic [7:0] y, y_al, y_c;
    logic       valid, valid_al, valid_c;
`ifdef DECODER_3_PARITY_EN
    logic       a_par = 1'b0;
    logic       err, err_al, err_c;
    logic       err_model = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] y;
        logic       v;
        logic [7:0] y_al;
    } exp_t;
    exp_t sb[$];

    decoder_3 #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .y(y), .a(a), .en(en), .valid(valid)
`ifdef DECODER_3_PARITY_EN
        , .a_par(a_par), .err(err)
`endif
    );

    decoder_3 #(.ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) dut_al (
        .clk(clk), .rst(rst), .y(y_al), .a(a), .en(en), .valid(valid_al)
`ifdef DECODER_3_PARITY_EN
        , .a_par(a_par), .err(err_al)
`endif
    );

    decoder_3 #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .y(y_c), .a(a), .en(en), .valid(valid_c)
`ifdef DECODER_3_PARITY_EN
        , .a_par(a_par), .err(err_c)
`endif
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one decode at the falling edge, check the combinational copy, then the registered ones.
    task automatic step(input logic e, input logic [2:0] av, input logic par_ok);
        exp_t       x;
        logic [7:0] hot;
        @(negedge clk);
        en = e;
        a  = av;
`ifdef DECODER_3_PARITY_EN
        a_par = par_ok ? (^av) : ~(^av);
        if (e && !par_ok) err_model = 1'b1;
`endif
        hot    = (e && par_ok) ? (8'h01 << av) : 8'h00;
        x.y    = hot;
        x.v    = e && par_ok;
        x.y_al = ~hot;
        sb.push_back(x);
        #1;
        check("comb_y", y_c, hot);
        check("comb_valid", {7'b0, valid_c}, {7'b0, x.v});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        $display("step en=%b a=%b y=%h valid=%b y_al=%h", e, av, y, valid, y_al);
        check("reg_y", y, x.y);
        check("reg_valid", {7'b0, valid}, {7'b0, x.v});
        check("al_y", y_al, x.y_al);
        check("al_valid", {7'b0, valid_al}, {7'b0, x.v});
`ifdef DECODER_3_PARITY_EN
        check("err", {7'b0, err}, {7'b0, err_model});
`endif
    endtask

    initial begin
        // Reset with clock stopped
        #3 rst = 1'b1;
        #1;
        check("rst_y", y, 8'h00);
        check("rst_valid", {7'b0, valid}, 8'h00);
        check("rst_y_al", y_al, 8'hFF);
        check("rst_y_comb", y_c, 8'h00);
`ifdef DECODER_3_PARITY_EN
        check("rst_err", {7'b0, err}, 8'h00);
`endif
        clk_run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Disabled with unknown select
        for (int i = 0; i < 3; i++) step(1'b0, 3'bxxx, 1'b1);

        // Full sweep, back-to-back
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 1'b1);

        // Polarity pair
        step(1'b1, 3'b011, 1'b1);
        step(1'b0, 3'b011, 1'b1);

        // Reset between edges with a decode pending
        step(1'b1, 3'b101, 1'b1);
        @(negedge clk);
        en = 1'b1;
        a  = 3'b110;
        #1 rst = 1'b1;
        #1;
        check("midrst_y", y, 8'h00);
        check("midrst_valid", {7'b0, valid}, 8'h00);
        check("midrst_y_al", y_al, 8'hFF);
        check("midrst_y_comb", y_c, 8'h00);
        @(posedge clk);
        #1;
        check("midrst_hold_y", y, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_y", y, 8'h00);
        check("post_rst_valid", {7'b0, valid}, 8'h00);

        // First enabled decode after release
        step(1'b1, 3'b010, 1'b1);

`ifdef DECODER_3_PARITY_EN
        // Bad parity blanks the decode and sets a sticky error
        step(1'b1, 3'b110, 1'b0);
        step(1'b1, 3'b110, 1'b1);
        step(1'b0, 3'b000, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        err_model = 1'b0;
        #1;
        check("err_cleared", {7'b0, err}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 3'b001, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
